// File: rtl/serial_alu_seq_if.sv
// Request/response bundle for the bit-serial add/sub sequencer.
// The decoder drives the master side; the ALU sits on the slave side.
interface serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, result, flag_c, flag_v, flag_z
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, result, flag_c, flag_v, flag_z
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract: one full_adder cell time-shared over WIDTH cycles,
// LSB first, with the carry held in a flop between bits.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_alu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_flag_z;

  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {w_sum, r_res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B here, carry-in of 1 below.
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res_sr <= w_res_next;
          r_carry  <= w_cout;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            // r_carry here is the carry into the MSB, so V = cin_msb ^ cout.
            r_result <= w_res_next;
            r_flag_c <= w_cout;
            r_flag_v <= r_carry ^ w_cout;
            r_flag_z <= (w_res_next == '0);
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = (r_state == IDLE);
  assign bus.busy   = (r_state == RUN);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_result;
  assign bus.flag_c = r_flag_c;
  assign bus.flag_v = r_flag_v;
  assign bus.flag_z = r_flag_z;
endmodule
